// File: rtl/periph_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : periph_arbiter
// Description : Two-master arbiter in front of a shared peripheral bus.
//               Address decode into ten slave windows, one transaction in
//               flight, alternating priority on contention, timeout to an
//               error response, and local error response on decode miss.
// Revision    : 1.0 - initial release
// ============================================================================
module periph_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             m_req_i,
    input  logic [1:0]             m_we_i,
    input  logic [1:0][ADDR_W-1:0] m_addr_i,
    input  logic [1:0][63:0]       m_wdata_i,
    input  logic [1:0][7:0]        m_be_i,
    output logic [1:0]             m_gnt_o,
    output logic [1:0]             m_rvalid_o,
    output logic [63:0]            m_rdata_o,
    output logic                   m_err_o,
    output logic                   s_req_o,
    output logic                   s_we_o,
    output logic [ADDR_W-1:0]      s_addr_o,
    output logic [63:0]            s_wdata_o,
    output logic [7:0]             s_be_o,
    output logic [9:0]             s_sel_o,
    input  logic                   s_gnt_i,
    input  logic                   s_rvalid_i,
    input  logic [63:0]            s_rdata_i
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_ISSUE   = 2'd1;
    localparam logic [1:0]  c_WAIT    = 2'd2;
    localparam logic [1:0]  c_ERR     = 2'd3;
    localparam int          c_NSLV    = 10;
    // Decode arithmetic runs at least 64 bits wide so base+len never wraps.
    localparam int          c_EW      = (ADDR_W > 64) ? ADDR_W : 64;
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

    // Slave window bases, indexed by select bit.
    function automatic logic [63:0] f_base(input int idx);
        case (idx)
            0:       f_base = 64'h0000_0000_8000_0000; // DRAM
            1:       f_base = 64'h0000_0000_4000_0000; // GPIO
            2:       f_base = 64'h0000_0000_3000_0000; // Ethernet
            3:       f_base = 64'h0000_0000_2000_0000; // SPI
            4:       f_base = 64'h0000_0000_1800_0000; // Timer
            5:       f_base = 64'h0000_0000_1000_0000; // UART
            6:       f_base = 64'h0000_0000_0C00_0000; // PLIC
            7:       f_base = 64'h0000_0000_0200_0000; // CLINT
            8:       f_base = 64'h0000_0000_0001_0000; // ROM
            default: f_base = 64'h0000_0000_0000_0000; // Debug
        endcase
    endfunction

    // Slave window lengths, indexed by select bit.
    function automatic logic [63:0] f_len(input int idx);
        case (idx)
            0:       f_len = 64'h0000_0000_4000_0000;
            1:       f_len = 64'h0000_0000_0000_1000;
            2:       f_len = 64'h0000_0000_0001_0000;
            3:       f_len = 64'h0000_0000_0080_0000;
            4:       f_len = 64'h0000_0000_0000_1000;
            5:       f_len = 64'h0000_0000_0000_1000;
            6:       f_len = 64'h0000_0000_03FF_FFFF;
            7:       f_len = 64'h0000_0000_000C_0000;
            8:       f_len = 64'h0000_0000_0001_0000;
            default: f_len = 64'h0000_0000_0000_1000;
        endcase
    endfunction

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_ptr;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata;
    logic [7:0]        r_be;
    logic [9:0]        r_sel;
    logic [15:0]       r_cnt;
    logic              r_rsp_valid;
    logic [63:0]       r_rdata;

    logic              w_win;
    logic              w_grant;
    logic              w_busy;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_win_addr;
    logic [c_EW-1:0]   w_addr_ext;
    logic [c_NSLV-1:0] w_hit;

    // A response pulse occupies the first IDLE cycle, so arbitration waits.
    assign w_grant    = (r_state == c_IDLE) && (|m_req_i) && !r_rsp_valid;
    assign w_busy     = (r_state == c_ISSUE) || (r_state == c_WAIT);
    assign w_timeout  = w_busy && ((r_cnt + 16'd1) == c_TIMEOUT);
    assign w_win_addr = m_addr_i[w_win];
    assign w_addr_ext = c_EW'(w_win_addr);

    // Winner selection: sole requester wins, contention resolved by pointer.
    always_comb begin
        w_win = 1'b0;
        case (m_req_i)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = r_ptr;
            default: w_win = 1'b0;
        endcase
    end

    // Offset form of base <= addr < base+len avoids the base+len sum.
    for (genvar gi = 0; gi < c_NSLV; gi++) begin : g_decode
        localparam logic [c_EW-1:0] c_B = c_EW'(f_base(gi));
        localparam logic [c_EW-1:0] c_L = c_EW'(f_len(gi));
        assign w_hit[gi] = (w_addr_ext >= c_B) && ((w_addr_ext - c_B) < c_L);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a response beats a timeout, which beats a bus grant.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = (|w_hit) ? c_ISSUE : c_ERR;
                end
            end
            c_ISSUE: begin
                if (s_rvalid_i) begin
                    w_state_nxt = c_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = c_ERR;
                end else if (s_gnt_i) begin
                    w_state_nxt = c_WAIT;
                end
            end
            c_WAIT: begin
                if (s_rvalid_i) begin
                    w_state_nxt = c_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = c_ERR;
                end
            end
            c_ERR:   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Request capture, priority pointer, timeout counter and response data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_grant) begin
                r_ptr   <= ~w_win;
                r_owner <= w_win;
                r_we    <= m_we_i[w_win];
                r_addr  <= w_win_addr;
                r_wdata <= m_wdata_i[w_win];
                r_be    <= m_be_i[w_win];
                r_sel   <= w_hit;
                r_cnt   <= '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_busy && s_rvalid_i) begin
                r_rsp_valid <= 1'b1;
                r_rdata     <= s_rdata_i;
            end
        end
    end

    // Output decode; grant is suppressed while reset is held.
    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        s_sel_o    = '0;
        if (w_grant && !rst_i) begin
            m_gnt_o[w_win] = 1'b1;
        end
        if (r_rsp_valid || (r_state == c_ERR)) begin
            m_rvalid_o[r_owner] = 1'b1;
        end
        if (w_busy) begin
            s_sel_o = r_sel;
        end
        m_err_o   = (r_state == c_ERR);
        s_req_o   = (r_state == c_ISSUE);
        m_rdata_o = r_rsp_valid ? r_rdata : 64'd0;
    end

    assign s_we_o    = r_we;
    assign s_addr_o  = r_addr;
    assign s_wdata_o = r_wdata;
    assign s_be_o    = r_be;

endmodule
`default_nettype wire
